// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 4;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: trial subtract via add-with-complement,
// keep the trial on no-borrow, otherwise restore the shifted remainder.
module div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH+1:0] sum;

    // rem_in + ~{0,divisor} + 1; the carry out of bit WIDTH means rem_in >= divisor.
    assign sum     = {1'b0, rem_in} + {2'b01, ~divisor} + {{(WIDTH+1){1'b0}}, 1'b1};
    assign q_bit   = sum[WIDTH+1];
    assign rem_out = q_bit ? sum[WIDTH:0] : rem_in;

endmodule

// File: rtl/seq_divider.sv
// Unsigned sequential restoring divider, one quotient bit per cycle, MSB first,
// with independent operand and result valid/ready handshakes.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // in_ready depends only on state, and once out_valid rises the result
    // registers hold until the edge that sees out_ready.
    state_t           state;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] quo;
    logic [WIDTH:0]   rem;
    logic [CNT_W-1:0] cnt;
    logic             dbz;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   step_rem;
    logic             step_q;

    assign shifted = (rem << 1) | {{WIDTH{1'b0}}, quo[WIDTH-1]};

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (shifted),
        .divisor (div_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            div_q <= '0;
            quo   <= '0;
            rem   <= '0;
            cnt   <= '0;
            dbz   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (divisor == '0) begin
                            quo   <= '1;
                            rem   <= {1'b0, dividend};
                            dbz   <= 1'b1;
                            state <= DONE;
                        end else begin
                            div_q <= divisor;
                            quo   <= dividend;
                            rem   <= '0;
                            cnt   <= '0;
                            dbz   <= 1'b0;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem <= step_rem;
                    quo <= {quo[WIDTH-2:0], step_q};
                    cnt <= cnt + 1'b1;
                    // The edge that runs iteration WIDTH-1 is the last one.
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == DONE);
    assign quotient    = quo;
    assign remainder   = rem[WIDTH-1:0];
    assign div_by_zero = dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=4): handshake timing, divide-by-zero,
// backpressure, asynchronous reset mid-operation and a full operand sweep.
module tb_seq_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] exp_q[$];

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        int t;
        t = 0;
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("accept_timeout", 32'(t < 50), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid; optionally drives
    // junk operands with in_valid high while the divider is busy.
    task automatic wait_result(input bit noise, output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (noise) begin
                check("busy_in_ready", 32'(in_ready), 32'd0);
                in_valid = 1'b1;
                dividend = 4'($urandom_range(0, 15));
                divisor  = 4'($urandom_range(1, 15));
            end
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check("result_timeout", 32'(lat < 40), 32'd1);
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] q,
                                input logic [W-1:0] r, input logic z);
        check({tag, "_q"}, 32'(quotient), 32'(q));
        check({tag, "_r"}, 32'(remainder), 32'(r));
        check({tag, "_dbz"}, 32'(div_by_zero), 32'(z));
    endtask

    // With out_ready high, the next edge must release the result.
    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_released"}, 32'(out_valid), 32'd0);
        check({tag, "_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        logic [W-1:0] a_list[3];
        logic [W-1:0] b_list[3];
        logic [W-1:0] q_list[3];
        logic [W-1:0] r_list[3];

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check_result("rst", 4'd0, 4'd0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // 7/2 with the consumer always ready
        out_ready = 1'b1;
        send(4'd7, 4'd2);
        check("7_2_in_ready_busy", 32'(in_ready), 32'd0);
        wait_result(1'b0, lat);
        check("7_2_latency", 32'(lat), 32'd4);
        check_result("7_2", 4'd3, 4'd1, 1'b0);
        check("7_2_in_ready_done", 32'(in_ready), 32'd0);
        release_result("7_2");

        // Back-to-back with junk operands presented while busy
        a_list = '{4'd15, 4'd15, 4'd1};
        b_list = '{4'd15, 4'd1, 4'd15};
        q_list = '{4'd1, 4'd15, 4'd0};
        r_list = '{4'd0, 4'd0, 4'd1};
        for (int i = 0; i < 3; i++) begin
            send(a_list[i], b_list[i]);
            wait_result(1'b1, lat);
            check("b2b_latency", 32'(lat), 32'd4);
            check_result("b2b", q_list[i], r_list[i], 1'b0);
            release_result("b2b");
        end

        // Divide by zero: the accept edge itself registers the result
        send(4'd5, 4'd0);
        check("5_0_valid_now", 32'(out_valid), 32'd1);
        check_result("5_0", 4'hF, 4'd5, 1'b1);
        release_result("5_0");
        send(4'd9, 4'd4);
        wait_result(1'b0, lat);
        check("9_4_latency", 32'(lat), 32'd4);
        check_result("9_4", 4'd2, 4'd1, 1'b0);
        release_result("9_4");

        // Backpressure: 13/3 held for 10 cycles
        out_ready = 1'b0;
        send(4'd13, 4'd3);
        wait_result(1'b0, lat);
        check("13_3_latency", 32'(lat), 32'd4);
        repeat (10) begin
            check("13_3_hold_valid", 32'(out_valid), 32'd1);
            check_result("13_3_hold", 4'd4, 4'd1, 1'b0);
            @(negedge clk);
        end
        release_result("13_3");

        // Asynchronous reset between edges during CALC of 12/5
        send(4'd12, 4'd5);
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check_result("arst", 4'd0, 4'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check("arst_no_valid", 32'(out_valid), 32'd0);
        end
        send(4'd12, 4'd5);
        wait_result(1'b0, lat);
        check("12_5_latency", 32'(lat), 32'd4);
        check_result("12_5", 4'd2, 4'd2, 1'b0);
        release_result("12_5");

        // Full sweep with random result stalls
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                logic [W-1:0] eq;
                logic [W-1:0] er;
                int k;
                if (b == 0) begin
                    exp_q.push_back(4'hF);
                    exp_q.push_back(4'(a));
                end else begin
                    exp_q.push_back(4'(a / b));
                    exp_q.push_back(4'(a % b));
                end
                out_ready = 1'b0;
                send(4'(a), 4'(b));
                wait_result(1'b0, lat);
                check("sweep_latency", 32'(lat), (b == 0) ? 32'd0 : 32'd4);
                eq = exp_q.pop_front();
                er = exp_q.pop_front();
                check_result("sweep", eq, er, b == 0);
                k = $urandom_range(0, 3);
                repeat (k) begin
                    @(negedge clk);
                    check("sweep_stall_valid", 32'(out_valid), 32'd1);
                    check("sweep_stall_q", 32'(quotient), 32'(eq));
                end
                release_result("sweep");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
